// File: rtl/sprite_compositor.sv
// Sprite compositor: renders NUM_SPRITES solid rectangles over a bordered playfield, two-stage pixel pipeline.
// Optional build macro SPRITE_COLLISION_EN adds per-frame sprite overlap detection.
module sprite_compositor #(
  parameter int         NUM_SPRITES = 3,
  parameter int         SPRITE_W    = 10,
  parameter int         SPRITE_H    = 10,
  parameter int         BORDER_W    = 11,
  parameter logic [2:0] BORDER_RGB  = 3'b001
) (
  input  logic                     VGA_clk,
  input  logic                     resetn,
  input  logic [9:0]               xCount,
  input  logic [9:0]               yCount,
  input  logic                     displayArea,
  input  logic                     frame_start,
  input  logic [NUM_SPRITES*10-1:0] sprite_x,
  input  logic [NUM_SPRITES*9-1:0]  sprite_y,
  input  logic [NUM_SPRITES-1:0]    sprite_en,
  input  logic [NUM_SPRITES*3-1:0]  sprite_rgb,
  output logic [7:0]               VGA_R,
  output logic [7:0]               VGA_G,
  output logic [7:0]               VGA_B,
  output logic [NUM_SPRITES-1:0]    collision,
  output logic                     collision_valid,
  output logic [15:0]              frame_count
);

  localparam logic [10:0] BORDER_LO = 11'(BORDER_W);
  localparam logic [10:0] BORDER_XR = 11'(640 - BORDER_W);
  localparam logic [10:0] BORDER_YB = 11'(480 - BORDER_W);

  // Shadow copies of the sprite controls, only refreshed in vertical blanking.
  logic [NUM_SPRITES*10-1:0] sx_q, sx_d;
  logic [NUM_SPRITES*9-1:0]  sy_q, sy_d;
  logic [NUM_SPRITES-1:0]    en_q, en_d;
  logic [NUM_SPRITES*3-1:0]  rgb_q, rgb_d;
  logic [15:0]               fc_q, fc_d;

  logic [NUM_SPRITES-1:0]    hit_q, hit_d;
  logic                      border_q, border_d;
  logic                      de1_q, de1_d;
  logic [2:0]                pix_q, pix_d;

  // NOTE: every combinational output gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    sx_d  = sx_q;
    sy_d  = sy_q;
    en_d  = en_q;
    rgb_d = rgb_q;
    fc_d  = fc_q;
    if (frame_start) begin
      sx_d  = sprite_x;
      sy_d  = sprite_y;
      en_d  = sprite_en;
      rgb_d = sprite_rgb;
      fc_d  = fc_q + 16'd1;
    end
  end

  // Stage 1: sprite/border hit tests in 11-bit arithmetic so right/bottom edges clip instead of wrapping.
  always_comb begin
    logic [10:0] x11, y11, x_lo, x_hi, y_lo, y_hi;
    x11      = {1'b0, xCount};
    y11      = {1'b0, yCount};
    x_lo     = '0;
    x_hi     = '0;
    y_lo     = '0;
    y_hi     = '0;
    hit_d    = '0;
    de1_d    = displayArea;
    border_d = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      x_lo     = {1'b0, sx_q[10*i +: 10]};
      x_hi     = x_lo + 11'(SPRITE_W);
      y_lo     = {2'b0, sy_q[9*i +: 9]};
      y_hi     = y_lo + 11'(SPRITE_H);
      hit_d[i] = en_q[i] && (x11 >= x_lo) && (x11 < x_hi) && (y11 >= y_lo) && (y11 < y_hi);
    end
    if (BORDER_W > 0) begin
      border_d = (x11 < BORDER_LO) || (x11 >= BORDER_XR) || (y11 < BORDER_LO) || (y11 >= BORDER_YB);
    end
  end

  // Stage 2: colour resolve; scanning downward lets the lowest-index hit overwrite the rest.
  always_comb begin
    pix_d = 3'b000;
    if (de1_q) begin
      if (border_q) pix_d = BORDER_RGB;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
        if (hit_q[i]) pix_d = rgb_q[3*i +: 3];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: reset clears the whole datapath, shadows included, so sprites stay hidden until the next frame_start.
  always_ff @(posedge VGA_clk) begin
    if (!resetn) begin
      sx_q     <= '0;
      sy_q     <= '0;
      en_q     <= '0;
      rgb_q    <= '0;
      fc_q     <= '0;
      hit_q    <= '0;
      border_q <= 1'b0;
      de1_q    <= 1'b0;
      pix_q    <= '0;
    end else begin
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      en_q     <= en_d;
      rgb_q    <= rgb_d;
      fc_q     <= fc_d;
      hit_q    <= hit_d;
      border_q <= border_d;
      de1_q    <= de1_d;
      pix_q    <= pix_d;
    end
  end

  assign VGA_R       = {8{pix_q[2]}};
  assign VGA_G       = {8{pix_q[1]}};
  assign VGA_B       = {8{pix_q[0]}};
  assign frame_count = fc_q;

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:0] acc_q, acc_d;
  logic [NUM_SPRITES-1:0] coll_q, coll_d;
  logic                   cv_q, cv_d;

  // A frame_start cycle closes the old frame, yet its own hits seed the new accumulator.
  always_comb begin
    logic [NUM_SPRITES-1:0] overlap;
    overlap = (de1_q && ($countones(hit_q) >= 2)) ? hit_q : '0;
    acc_d   = acc_q | overlap;
    coll_d  = coll_q;
    cv_d    = 1'b0;
    if (frame_start) begin
      acc_d  = overlap;
      coll_d = acc_q;
      cv_d   = 1'b1;
    end
  end

  always_ff @(posedge VGA_clk) begin
    if (!resetn) begin
      acc_q  <= '0;
      coll_q <= '0;
      cv_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      coll_q <= coll_d;
      cv_q   <= cv_d;
    end
  end

  assign collision       = coll_q;
  assign collision_valid = cv_q;
`else
  assign collision       = '0;
  assign collision_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor against a pixel-level behavioural model.
module tb_sprite_compositor;
  localparam int NS = 3;
  localparam int SW = 10;
  localparam int SH = 10;
  localparam int BW = 11;
  localparam logic [2:0] BRGB = 3'b001;

  logic              VGA_clk = 1'b0;
  logic              resetn = 1'b0;
  logic [9:0]        xCount = '0, yCount = '0;
  logic              displayArea = 1'b0, frame_start = 1'b0;
  logic [NS*10-1:0]  sprite_x = '0;
  logic [NS*9-1:0]   sprite_y = '0;
  logic [NS-1:0]     sprite_en = '0;
  logic [NS*3-1:0]   sprite_rgb = '0;
  logic [7:0]        VGA_R, VGA_G, VGA_B;
  logic [NS-1:0]     collision;
  logic              collision_valid;
  logic [15:0]       frame_count;

  int vectors = 0;
  int miscompares = 0;

  sprite_compositor #(.NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH), .BORDER_W(BW), .BORDER_RGB(BRGB)) dut (
    .VGA_clk(VGA_clk), .resetn(resetn), .xCount(xCount), .yCount(yCount),
    .displayArea(displayArea), .frame_start(frame_start),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en), .sprite_rgb(sprite_rgb),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .collision(collision), .collision_valid(collision_valid), .frame_count(frame_count)
  );

  always #20 VGA_clk = ~VGA_clk;

  // Model state: the sprite set currently on screen and what the screen should show.
  int          m_sx[NS], m_sy[NS];
  bit          m_en[NS];
  logic [2:0]  m_rgb[NS];
  logic [2:0]  exp_now = '0, exp_pend = '0;
  int          m_fc = 0;
  logic [NS-1:0] m_coll = '0, m_acc = '0, m_pend = '0;
  logic          m_valid = 1'b0;

  function automatic logic [2:0] model_colour(int x, int y, bit de);
    if (!de) return 3'b000;
    for (int i = 0; i < NS; i++)
      if (m_en[i] && x >= m_sx[i] && x < m_sx[i] + SW && y >= m_sy[i] && y < m_sy[i] + SH)
        return m_rgb[i];
    if (BW > 0 && (x < BW || x >= 640 - BW || y < BW || y >= 480 - BW)) return BRGB;
    return 3'b000;
  endfunction

  function automatic logic [NS-1:0] model_hits(int x, int y, bit de);
    logic [NS-1:0] h = '0;
    for (int i = 0; i < NS; i++)
      h[i] = de && m_en[i] && x >= m_sx[i] && x < m_sx[i] + SW && y >= m_sy[i] && y < m_sy[i] + SH;
    return h;
  endfunction

  function automatic logic [23:0] expand(logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  task automatic set_sprite(int i, int x, int y, bit en, logic [2:0] rgb);
    sprite_x[10*i +: 10] = 10'(x);
    sprite_y[9*i +: 9]   = 9'(y);
    sprite_en[i]         = en;
    sprite_rgb[3*i +: 3] = rgb;
  endtask

  // One pixel clock: drive inputs, advance the model at the edge, settle before the caller compares.
  task automatic tick(int x, int y, bit de, bit fs, bit rst_n);
    logic [NS-1:0] overlap;
    xCount = 10'(x); yCount = 10'(y); displayArea = de; frame_start = fs; resetn = rst_n;
    @(posedge VGA_clk);
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) m_en[i] = 1'b0;
      exp_now = '0; exp_pend = '0; m_fc = 0;
      m_coll = '0; m_acc = '0; m_pend = '0; m_valid = 1'b0;
    end else begin
      exp_now  = exp_pend;
      exp_pend = model_colour(x, y, de);
`ifdef SPRITE_COLLISION_EN
      overlap = ($countones(m_pend) >= 2) ? m_pend : '0;
      if (fs) begin m_coll = m_acc; m_acc = overlap; m_valid = 1'b1; end
      else begin m_acc = m_acc | overlap; m_valid = 1'b0; end
      m_pend = model_hits(x, y, de);
`else
      overlap = '0;
`endif
      if (fs) begin
        for (int i = 0; i < NS; i++) begin
          m_sx[i] = int'(sprite_x[10*i +: 10]);
          m_sy[i] = int'(sprite_y[9*i +: 9]);
          m_en[i] = sprite_en[i];
          m_rgb[i] = sprite_rgb[3*i +: 3];
        end
        m_fc = (m_fc + 1) % 65536;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    vectors++;
    if ({VGA_R, VGA_G, VGA_B, collision, collision_valid, frame_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: rgb=%h coll=%b cv=%b fc=%0d, required all zero",
               {VGA_R, VGA_G, VGA_B}, collision, collision_valid, frame_count);
    end
    tick(0, 0, 0, 0, 1);
  endtask

  // Scans a rectangle of pixels with display enabled, comparing every cycle to the model.
  task automatic scan(string name, int x0, int x1, int y0, int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        tick(x, y, 1, 0, 1);
        vectors++;
        if ({VGA_R, VGA_G, VGA_B} !== expand(exp_now)) begin
          miscompares++;
          $display("FAIL %s pix(%0d,%0d): got %h, required %h", name, x, y, {VGA_R, VGA_G, VGA_B}, expand(exp_now));
        end
      end
  endtask

  task automatic test_single_sprite;
    set_sprite(0, 100, 50, 1, 3'b100);
    set_sprite(1, 0, 0, 0, 3'b010);
    set_sprite(2, 0, 0, 0, 3'b001);
    tick(0, 0, 0, 1, 1);
    scan("single", 97, 112, 49, 60);
    // Explicit pipeline-latency spot check: pixel (100,55) appears two edges after it is presented.
    tick(100, 55, 1, 0, 1);
    tick(101, 55, 1, 0, 1);
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hFF0000) begin
      miscompares++;
      $display("FAIL single_latency: got %h, required ff0000", {VGA_R, VGA_G, VGA_B});
    end
    tick(99, 55, 1, 0, 1);
    tick(110, 55, 1, 0, 1);
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin
      miscompares++;
      $display("FAIL single_left_edge x=99: got %h, required 000000", {VGA_R, VGA_G, VGA_B});
    end
    tick(111, 55, 1, 0, 1);
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin
      miscompares++;
      $display("FAIL single_right_edge x=110: got %h, required 000000", {VGA_R, VGA_G, VGA_B});
    end
  endtask

  task automatic test_priority;
    set_sprite(0, 200, 200, 1, 3'b100);
    set_sprite(1, 200, 200, 1, 3'b010);
    set_sprite(2, 205, 203, 1, 3'b011);
    tick(0, 0, 0, 1, 1);
    scan("priority", 196, 216, 199, 213);
  endtask

  task automatic test_shadow;
    set_sprite(0, 100, 50, 1, 3'b100);
    set_sprite(1, 0, 0, 0, 3'b010);
    set_sprite(2, 0, 0, 0, 3'b001);
    tick(0, 0, 0, 1, 1);
    scan("shadow_before", 98, 112, 55, 55);
    set_sprite(0, 300, 50, 1, 3'b100);
    scan("shadow_hold_old", 98, 112, 55, 56);
    scan("shadow_hold_new", 298, 312, 55, 55);
    tick(0, 0, 0, 1, 1);
    scan("shadow_after_old", 98, 112, 55, 55);
    scan("shadow_after_new", 298, 312, 55, 56);
  endtask

  task automatic test_edge_clip;
    set_sprite(0, 635, 475, 1, 3'b110);
    set_sprite(1, 0, 0, 0, 3'b010);
    set_sprite(2, 0, 0, 0, 3'b001);
    tick(0, 0, 0, 1, 1);
    scan("edge_bottom_right", 620, 639, 473, 479);
    scan("edge_no_wrap_top_left", 0, 14, 0, 5);
    scan("border_left_right", 0, 14, 240, 240);
    scan("border_right", 625, 639, 240, 240);
  endtask

  task automatic test_collision;
    set_sprite(0, 50, 50, 1, 3'b100);
    set_sprite(1, 400, 300, 1, 3'b010);
    set_sprite(2, 405, 305, 1, 3'b001);
    tick(0, 0, 0, 1, 1);
    scan("coll_overlap", 398, 416, 300, 312);
    scan("coll_apart", 48, 62, 50, 52);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 1);
    vectors++;
    if ({collision, collision_valid} !== {m_coll, m_valid}) begin
      miscompares++;
      $display("FAIL coll_report: got coll=%b cv=%b, required coll=%b cv=%b", collision, collision_valid, m_coll, m_valid);
    end
`ifdef SPRITE_COLLISION_EN
    vectors++;
    if ({collision, collision_valid} !== {3'b110, 1'b1}) begin
      miscompares++;
      $display("FAIL coll_expected_110: got coll=%b cv=%b, required coll=110 cv=1", collision, collision_valid);
    end
`endif
    tick(0, 0, 0, 0, 1);
    vectors++;
    if ({collision, collision_valid} !== {m_coll, 1'b0}) begin
      miscompares++;
      $display("FAIL coll_pulse_width: got coll=%b cv=%b, required coll=%b cv=0", collision, collision_valid, m_coll);
    end
    set_sprite(2, 500, 300, 1, 3'b001);
    tick(0, 0, 0, 1, 1);
    scan("coll_separated", 398, 416, 300, 310);
    scan("coll_separated2", 498, 512, 300, 302);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 1);
    vectors++;
    if ({collision, collision_valid} !== {m_coll, m_valid} || collision !== 3'b000) begin
      miscompares++;
      $display("FAIL coll_cleared: got coll=%b cv=%b, required coll=000 cv=%b", collision, collision_valid, m_valid);
    end
  endtask

  task automatic test_random;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NS; i++)
        set_sprite(i, $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 3) != 0, 3'($urandom));
      tick(0, 0, 0, 1, 1);
      for (int n = 0; n < 600; n++) begin
        int k, x, y;
        bit de;
        k = $urandom_range(0, NS - 1);
        if ($urandom_range(0, 1) == 1) begin
          x = int'(sprite_x[10*k +: 10]) + $urandom_range(0, 16) - 3;
          y = int'(sprite_y[9*k +: 9]) + $urandom_range(0, 14) - 2;
          if (x < 0) x = 0;
          if (x > 639) x = 639;
          if (y < 0) y = 0;
          if (y > 479) y = 479;
        end else begin
          x = $urandom_range(0, 639);
          y = $urandom_range(0, 479);
        end
        de = $urandom_range(0, 7) != 0;
        tick(x, y, de, 0, 1);
        vectors++;
        if ({VGA_R, VGA_G, VGA_B, collision, collision_valid} !== {expand(exp_now), m_coll, m_valid}) begin
          miscompares++;
          $display("FAIL random f%0d n%0d: got rgb=%h coll=%b cv=%b, required rgb=%h coll=%b cv=%b",
                   f, n, {VGA_R, VGA_G, VGA_B}, collision, collision_valid, expand(exp_now), m_coll, m_valid);
        end
      end
    end
  endtask

  task automatic test_frame_count;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    for (int i = 1; i <= 65536; i++) begin
      tick(0, 0, 0, 1, 1);
      if (i == 1 || i == 65535 || i == 65536) begin
        vectors++;
        if (frame_count !== 16'(m_fc)) begin
          miscompares++;
          $display("FAIL frame_count after %0d pulses: got %0d, required %0d", i, frame_count, m_fc);
        end
      end
    end
    vectors++;
    if (frame_count !== 16'd0) begin
      miscompares++;
      $display("FAIL frame_count_wrap: got %0d, required 0", frame_count);
    end
  endtask

  task automatic test_reset_mid_line;
    set_sprite(0, 100, 50, 1, 3'b100);
    tick(0, 0, 0, 1, 1);
    scan("midline_pre", 100, 105, 52, 52);
    tick(106, 52, 1, 0, 0);
    vectors++;
    if ({VGA_R, VGA_G, VGA_B, frame_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_line: got rgb=%h fc=%0d, required 0", {VGA_R, VGA_G, VGA_B}, frame_count);
    end
    tick(107, 52, 1, 0, 1);
    scan("midline_post_invisible", 98, 112, 52, 53);
    tick(0, 0, 0, 1, 1);
    scan("midline_after_fs", 98, 112, 53, 53);
  endtask

  initial begin
    test_reset;
    test_single_sprite;
    test_priority;
    test_shadow;
    test_edge_clip;
    test_collision;
    test_random;
    test_frame_count;
    test_reset_mid_line;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
